axi4_write_slave: RTL and testbench

AXI4 memory-mapped write-channel slave: accepts AW, W and B channel transactions from an AXI4 master and commits burst data into a word-addressed on-chip memory of MEMORY_DEPTH words. It is the design-under-test that the write-path bench drives. It returns OKAY for in-range, well-formed bursts and SLVERR otherwise. A registered side-band debug read port exposes memory contents for scoreboard checks.

---
 rtl/axi4_write_slave_pkg.sv | 17 +
 rtl/axi_wr_mem.sv | 26 ++
 rtl/axi4_write_slave.sv | 148 ++++++++++++++
 tb/tb_axi4_write_slave.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_write_slave_pkg.sv
// Shared types for the AXI4 write slave: response codes, FSM states and word geometry.
package axi_enum;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        RESP
    } wr_state_t;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/axi_wr_mem.sv
// Word memory with a synchronous write port and a registered read port.
// There is no reset, so the array can map onto block RAM.
module axi_wr_mem #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 1024,
    localparam int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // A read of the word being written on the same edge returns the old contents.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/axi4_write_slave.sv
// AXI4 write-channel slave (AW/W/B) committing INCR bursts into axi_wr_mem.
// Define AXI_WR_4K_CHECK_EN to also reject bursts that cross a 4 KB boundary.
module axi4_write_slave
    import axi_enum::*;
#(
    parameter  int DATA_WIDTH   = 32,
    parameter  int ADDR_WIDTH   = 16,
    parameter  int MEMORY_DEPTH = 1024,
    localparam int IDX_W        = $clog2(MEMORY_DEPTH)
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic [7:0]            AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [IDX_W-1:0]      dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_rdata
);

    localparam int EW = ADDR_WIDTH + 10;
    localparam logic [EW-1:0] MEM_BYTES = EW'(MEMORY_DEPTH * BYTES_PER_WORD);

    wr_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic [2:0]            size_q, size_d;
    logic                  err_q, err_d;
    logic                  init_q;

    logic                  aw_hs, w_hs, b_hs, last_beat;
    logic                  aw_err, cross_4k;
    logic [EW-1:0]         last_byte;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  addr_unused;

    // Widened so a burst running past the top of the address space cannot wrap back in range.
    assign last_byte = EW'(AWADDR) + (EW'(AWLEN) + EW'(1)) * EW'(BYTES_PER_WORD) - EW'(1);

`ifdef AXI_WR_4K_CHECK_EN
    assign cross_4k = AWADDR[ADDR_WIDTH-1:12] != last_byte[ADDR_WIDTH-1:12];
`else
    assign cross_4k = 1'b0;
`endif

    assign aw_err = (AWSIZE != 3'd2) || (AWADDR[1:0] != 2'b00) ||
                    (last_byte >= MEM_BYTES) || cross_4k;

    assign aw_hs     = AWVALID && AWREADY;
    assign w_hs      = WVALID && WREADY;
    assign b_hs      = BVALID && BREADY;
    assign last_beat = (beat_cnt_q == len_q);

    // init_q holds AWREADY and dbg_rdata low until the first edge after reset release.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            size_q     <= '0;
            err_q      <= 1'b0;
            init_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            size_q     <= size_d;
            err_q      <= err_d;
            init_q     <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        size_d     = size_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (aw_hs) begin
                    addr_d     = AWADDR;
                    len_d      = AWLEN;
                    size_d     = AWSIZE;
                    beat_cnt_d = '0;
                    err_d      = aw_err;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (w_hs) begin
                    addr_d     = addr_q + ADDR_WIDTH'(BYTES_PER_WORD);
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    // The beat counter, not WLAST, decides where the burst ends.
                    if (WLAST != last_beat) begin
                        err_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (b_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        AWREADY = (state_q == IDLE) && init_q;
        WREADY  = (state_q == DATA);
        BVALID  = (state_q == RESP);
        BRESP   = (state_q == RESP && err_q) ? RESP_SLVERR : RESP_OKAY;
    end

    assign mem_we      = w_hs && !err_q;
    assign dbg_rdata   = init_q ? mem_rdata : '0;
    assign addr_unused = ^{addr_q[ADDR_WIDTH-1:IDX_W+2], addr_q[1:0], size_q};

    axi_wr_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEMORY_DEPTH)
    ) u_mem (
        .clk     (ACLK),
        .we_i    (mem_we),
        .waddr_i (addr_q[IDX_W+1:2]),
        .wdata_i (WDATA),
        .raddr_i (dbg_addr),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_axi4_write_slave.sv
// Self-checking bench for axi4_write_slave: expected BRESPs are queued at AW time
// and compared at the B handshake; memory is checked through the debug port.
module tb_axi4_write_slave;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [15:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [9:0]  dbg_addr;
    logic [31:0] dbg_rdata;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [1:0]  exp_q [$];
    logic [31:0] model [1024];

    always #5 ACLK = ~ACLK;

    axi4_write_slave dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .AWADDR    (AWADDR),
        .AWLEN     (AWLEN),
        .AWSIZE    (AWSIZE),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .WDATA     (WDATA),
        .WLAST     (WLAST),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .BRESP     (BRESP),
        .BVALID    (BVALID),
        .BREADY    (BREADY),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic wait_awready();
        int cnt = 0;
        while (AWREADY !== 1'b1 && cnt < 50) begin
            tick();
            cnt++;
        end
        check_eq("awready_seen", {31'd0, AWREADY}, 32'd1);
    endtask

    task automatic dbg_read(input int w);
        dbg_addr = 10'(w);
        tick();
        check_eq($sformatf("mem[0x%03h]", w), dbg_rdata, model[w]);
    endtask

    task automatic do_burst(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [31:0] base, input int last_at, input logic [1:0] exp_resp,
                            input int bready_delay, input bit stall);
        int         cnt;
        logic [1:0] resp_seen;
        logic [1:0] exp;
        AWADDR  = addr;
        AWLEN   = len;
        AWSIZE  = size;
        AWVALID = 1'b1;
        wait_awready();
        tick();
        AWVALID = 1'b0;
        exp_q.push_back(exp_resp);
        check_eq("aw_awready_low", {31'd0, AWREADY}, 32'd0);
        check_eq("aw_wready_high", {31'd0, WREADY}, 32'd1);
        for (int i = 0; i <= int'(len); i++) begin
            if (stall && i == 1) begin
                WVALID = 1'b0;
                tick();
                tick();
                check_eq("stall_wready", {31'd0, WREADY}, 32'd1);
                check_eq("stall_bvalid", {31'd0, BVALID}, 32'd0);
            end
            WDATA  = base + 32'(i);
            WLAST  = (i == last_at);
            WVALID = 1'b1;
            cnt = 0;
            while (WREADY !== 1'b1 && cnt < 50) begin
                tick();
                cnt++;
            end
            if (WREADY !== 1'b1) check_eq("w_timeout", {31'd0, WREADY}, 32'd1);
            tick();
            if (exp_resp == OKAY) model[int'(addr >> 2) + i] = base + 32'(i);
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
        check_eq("last_wready_low", {31'd0, WREADY}, 32'd0);
        check_eq("last_bvalid_high", {31'd0, BVALID}, 32'd1);
        for (int i = 0; i < bready_delay; i++) begin
            tick();
            check_eq("hold_bvalid", {31'd0, BVALID}, 32'd1);
            check_eq("hold_bresp", {30'd0, BRESP}, {30'd0, exp_resp});
        end
        BREADY = 1'b1;
        cnt = 0;
        while (BVALID !== 1'b1 && cnt < 50) begin
            tick();
            cnt++;
        end
        resp_seen = BRESP;
        tick();
        BREADY = 1'b0;
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check_eq($sformatf("bresp@0x%04h", addr), {30'd0, resp_seen}, {30'd0, exp});
        end
        check_eq("b_awready_high", {31'd0, AWREADY}, 32'd1);
        check_eq("b_bvalid_low", {31'd0, BVALID}, 32'd0);
        $display("burst addr=0x%04h len=%0d size=%0d bresp=%02b", addr, len, size, resp_seen);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETn  = 1'b0;
        AWADDR   = '0;
        AWLEN    = '0;
        AWSIZE   = 3'd2;
        AWVALID  = 1'b0;
        WDATA    = '0;
        WLAST    = 1'b0;
        WVALID   = 1'b0;
        BREADY   = 1'b0;
        dbg_addr = '0;
        repeat (3) tick();
        check_eq("rst_awready", {31'd0, AWREADY}, 32'd0);
        check_eq("rst_wready", {31'd0, WREADY}, 32'd0);
        check_eq("rst_bvalid", {31'd0, BVALID}, 32'd0);
        check_eq("rst_bresp", {30'd0, BRESP}, 32'd0);
        check_eq("rst_dbg_rdata", dbg_rdata, 32'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        check_eq("rel_awready_before_edge", {31'd0, AWREADY}, 32'd0);
        tick();
        check_eq("rel_awready_after_edge", {31'd0, AWREADY}, 32'd1);

        // Single beat, then a 4-beat INCR burst.
        do_burst(16'h0010, 8'd0, 3'd2, 32'hDEADBEEF, 0, OKAY, 0, 1'b0);
        dbg_read(4);
        do_burst(16'h0100, 8'd3, 3'd2, 32'd1, 3, OKAY, 0, 1'b1);
        for (int w = 'h40; w <= 'h43; w++) dbg_read(w);

        // Top-of-memory edge and fully out of range.
        do_burst(16'h0FFC, 8'd0, 3'd2, 32'hA5A50000, 0, OKAY, 0, 1'b0);
        do_burst(16'h0FFC, 8'd1, 3'd2, 32'hBAD00000, 1, SLVERR, 0, 1'b0);
        dbg_read('h3FF);
        do_burst(16'h1000, 8'd0, 3'd2, 32'hBAD10000, 0, SLVERR, 0, 1'b0);

        // Bad size and bad alignment leave preloaded words untouched.
        do_burst(16'h0200, 8'd0, 3'd2, 32'h11110000, 0, OKAY, 0, 1'b0);
        do_burst(16'h0200, 8'd0, 3'd1, 32'hBAD20000, 0, SLVERR, 0, 1'b0);
        dbg_read('h80);
        do_burst(16'h0000, 8'd0, 3'd2, 32'h22220000, 0, OKAY, 0, 1'b0);
        do_burst(16'h0002, 8'd0, 3'd2, 32'hBAD30000, 0, SLVERR, 0, 1'b0);
        dbg_read(0);

        // Early WLAST: beat 0 lands (error not yet flagged), later beats do not.
        do_burst(16'h0300, 8'd2, 3'd2, 32'h33330000, 2, OKAY, 0, 1'b0);
        do_burst(16'h0300, 8'd2, 3'd2, 32'h44440000, 0, SLVERR, 0, 1'b0);
        model['hC0] = 32'h44440000;
        for (int w = 'hC0; w <= 'hC2; w++) dbg_read(w);

        // B backpressure.
        do_burst(16'h0400, 8'd1, 3'd2, 32'h66660000, 1, OKAY, 5, 1'b0);
        dbg_read('h101);

        // Reset in the middle of a DATA phase.
        AWADDR  = 16'h0500;
        AWLEN   = 8'd3;
        AWSIZE  = 3'd2;
        AWVALID = 1'b1;
        wait_awready();
        tick();
        AWVALID = 1'b0;
        exp_q.push_back(OKAY);
        WDATA  = 32'h55550000;
        WLAST  = 1'b0;
        WVALID = 1'b1;
        tick();
        model['h140] = 32'h55550000;
        WVALID = 1'b0;
        #2;
        ARESETn = 1'b0;
        #1;
        exp_q.delete();
        check_eq("midrst_wready", {31'd0, WREADY}, 32'd0);
        check_eq("midrst_awready", {31'd0, AWREADY}, 32'd0);
        check_eq("midrst_bvalid", {31'd0, BVALID}, 32'd0);
        tick();
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        check_eq("midrst_rel_awready_low", {31'd0, AWREADY}, 32'd0);
        tick();
        check_eq("midrst_rel_awready_high", {31'd0, AWREADY}, 32'd1);
        do_burst(16'h0600, 8'd1, 3'd2, 32'h77770000, 1, OKAY, 0, 1'b0);
        dbg_read('h140);
        dbg_read('h180);
        dbg_read('h181);

        // A few random in-range bursts.
        for (int k = 0; k < 4; k++) begin
            int          w;
            logic [7:0]  l;
            logic [31:0] d;
            w = int'($urandom_range(32'h280, 32'h2F0));
            l = 8'($urandom_range(0, 7));
            d = $urandom;
            do_burst(16'(w * 4), l, 3'd2, d, int'(l), OKAY, int'($urandom_range(0, 2)), k[0]);
            for (int j = 0; j <= int'(l); j++) dbg_read(w + j);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
